// File: rtl/mod_red_sched.sv
// rtl/mod_red_sched.sv - round-robin scheduler sharing one pipelined Montgomery reducer
// Tracks each in-flight op's requester through a valid/ID tag pipe; q changes only when drained.
module mod_red_sched #(
  parameter int NREQ  = 4,
  parameter int K     = 128,
  parameter int Q_LEN = 64,
  parameter int LAT   = 7,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_q_valid,
  input  logic [Q_LEN-1:0]            cfg_q,
  output logic                        cfg_q_ready,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*K-1:0]           req_C,
  output logic [NREQ-1:0]             req_ready,
  output logic [K-1:0]                red_C,
  output logic [Q_LEN-1:0]            red_q,
  input  logic [Q_LEN-1:0]            red_T,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [Q_LEN-1:0]            rsp_T,
  output logic                        busy,
  output logic [$clog2(LAT+2)-1:0]    inflight
);

  localparam int CW = $clog2(LAT+2);

  typedef enum logic [1:0] {NOQ, RUN, DRAIN} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_found;
  logic            grant;
  logic            load_q;
  logic            tag_v  [0:LAT];
  logic [ID_W-1:0] tag_id [0:LAT];

  // First asserted request searching upward from ptr+1 with wrap.
  always_comb begin
    int unsigned j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(j);
      end
    end
  end

  always_comb begin
    state_nx    = state;
    cfg_q_ready = 1'b0;
    load_q      = 1'b0;
    grant       = 1'b0;
    case (state)
      NOQ: begin
        cfg_q_ready = 1'b1;
        if (cfg_q_valid) begin
          load_q   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cfg_q_valid) state_nx = DRAIN;
        else             grant    = gnt_found;
      end
      DRAIN: begin
        cfg_q_ready = (inflight == '0);
        if (!cfg_q_valid) begin
          state_nx = RUN;
        end else if (inflight == '0) begin
          load_q   = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = NOQ;
    endcase
  end

  assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
  assign busy      = (inflight != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= NOQ;
      ptr       <= ID_W'(NREQ-1);
      red_C     <= '0;
      red_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_T     <= '0;
      inflight  <= '0;
      for (int i = 0; i <= LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (load_q) red_q <= cfg_q;
      if (grant) begin
        ptr   <= gnt_idx;
        red_C <= req_C[int'(gnt_idx)*K +: K];
      end
      tag_v[0]  <= grant;
      tag_id[0] <= gnt_idx;
      for (int i = 1; i <= LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      // The last tag stage lines up with red_T for the same op.
      rsp_valid <= tag_v[LAT];
      if (tag_v[LAT]) begin
        rsp_id <= tag_id[LAT];
        rsp_T  <= red_T;
      end
      if (grant && !tag_v[LAT])      inflight <= inflight + CW'(1);
      else if (!grant && tag_v[LAT]) inflight <= inflight - CW'(1);
    end
  end

endmodule

// File: tb/tb_mod_red_sched.sv
// tb/tb_mod_red_sched.sv - randomized self-checking bench for mod_red_sched
// Includes a fixed-latency Montgomery reducer stand-in and a round-robin/latency reference model.
`timescale 1ns/1ps
module tb_mod_red_sched;
  localparam int NREQ  = 4;
  localparam int K     = 128;
  localparam int Q_LEN = 64;
  localparam int LAT   = 7;
  localparam int ID_W  = 2;
  localparam int CW    = $clog2(LAT+2);

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_q_valid;
  logic [Q_LEN-1:0]    cfg_q;
  logic                cfg_q_ready;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*K-1:0]   req_C;
  logic [NREQ-1:0]     req_ready;
  logic [K-1:0]        red_C;
  logic [Q_LEN-1:0]    red_q;
  logic [Q_LEN-1:0]    red_T;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [Q_LEN-1:0]    rsp_T;
  logic                busy;
  logic [CW-1:0]       inflight;

  mod_red_sched #(.NREQ(NREQ), .K(K), .Q_LEN(Q_LEN), .LAT(LAT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_q_valid(cfg_q_valid), .cfg_q(cfg_q), .cfg_q_ready(cfg_q_ready),
    .req_valid(req_valid), .req_C(req_C), .req_ready(req_ready),
    .red_C(red_C), .red_q(red_q), .red_T(red_T),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_T(rsp_T),
    .busy(busy), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    int          id;
    logic [63:0] t;
  } rsp_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          mptr;
  logic [63:0] mq;
  rsp_t        rsp_log [$];
  rsp_t        exp_q [$];
  logic [63:0] stub [LAT];

  // Golden Montgomery reduction: C * 2^-64 mod q, for odd q and C < q*2^64.
  function automatic logic [63:0] redc(input logic [127:0] c, input logic [63:0] q);
    logic [63:0]  inv, m;
    logic [191:0] t;
    inv = 64'd1;
    for (int i = 0; i < 7; i++) inv = inv * (64'd2 - q * inv);
    m = c[63:0] * (64'd0 - inv);
    t = 192'(c) + 192'(m) * 192'(q);
    t = t >> 64;
    if (t >= 192'(q)) t = t - 192'(q);
    return t[63:0];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand_q();
    return rand64() | 64'h8000_0000_0000_0001;
  endfunction

  function automatic logic [127:0] rand_c(input logic [63:0] q);
    return {rand64() % q, rand64()};
  endfunction

  // Reducer stand-in: LAT edges from red_C/red_q to red_T.
  initial for (int i = 0; i < LAT; i++) stub[i] = '0;
  always @(posedge clk) begin
    stub[0] <= redc(red_C, red_q);
    for (int i = 1; i < LAT; i++) stub[i] <= stub[i-1];
  end
  assign red_T = stub[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rsp_t r;
    if (rst && rsp_valid) begin
      r.c = cyc; r.id = int'(rsp_id); r.t = rsp_T;
      rsp_log.push_back(r);
    end
  end

  function automatic int model_pick(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return -1;
  endfunction

  // Ops accepted at an edge <= c whose response edge is still ahead.
  function automatic int model_inflight(input int c);
    int n = 0;
    foreach (exp_q[i]) if ((exp_q[i].c - LAT - 1) <= c && c < exp_q[i].c) n++;
    return n;
  endfunction

  task automatic model_step(output logic [NREQ-1:0] er);
    int   g;
    rsp_t e;
    g  = model_pick(req_valid);
    er = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      e.c = cyc + LAT + 2; e.id = g; e.t = redc(req_C[g*K +: K], mq);
      exp_q.push_back(e);
      mptr = g;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [127:0] act [9];
    logic [127:0] expv [9];
    string        nm [9];
    rst = 1'b0; cfg_q_valid = 1'b0; cfg_q = '0; req_valid = '1; req_C = '1;
    repeat (3) @(posedge clk);
    #1;
    act  = '{128'(cfg_q_ready), 128'(req_ready), red_C, 128'(red_q), 128'(rsp_valid),
             128'(rsp_id), 128'(rsp_T), 128'(inflight), 128'(busy)};
    expv = '{128'd1, 128'd0, 128'd0, 128'd0, 128'd0, 128'd0, 128'd0, 128'd0, 128'd0};
    nm   = '{"cfg_q_ready", "req_ready", "red_C", "red_q", "rsp_valid",
             "rsp_id", "rsp_T", "inflight", "busy"};
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (act[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL reset_%s: got %0h expected %0h", nm[i], act[i], expv[i]);
      end
    end
    req_valid = '0; req_C = '0;
    tick();
    rst = 1'b1;
    mptr = NREQ - 1;
  endtask

  task automatic test_noq();
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < NREQ; r++) req_C[r*K +: K] = {rand64(), rand64()};
      #1;
      n_checks++;
      if (req_ready !== '0 || cfg_q_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL noq_ready cyc %0d: req_ready=%b cfg_q_ready=%b expected 0000/1", cyc, req_ready, cfg_q_ready);
      end
      tick();
      n_checks++;
      if (red_C !== '0) begin
        n_fail++;
        $display("FAIL noq_red_C: got %h expected 0", red_C);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] er;
    rsp_log.delete(); exp_q.delete();
    cfg_q_valid = 1'b1; cfg_q = 64'hFFFF_FFFF_0000_0001;
    #1;
    n_checks++;
    if (cfg_q_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_cfg_ready: got %b expected 1", cfg_q_ready);
    end
    tick();
    cfg_q_valid = 1'b0; mq = 64'hFFFF_FFFF_0000_0001;
    n_checks++;
    if (red_q !== mq) begin
      n_fail++; $display("FAIL single_red_q: got %h expected %h", red_q, mq);
    end
    req_valid = 4'b0100; req_C[2*K +: K] = {64'd5, 64'd0};
    #1;
    model_step(er);
    n_checks++;
    if (req_ready !== er) begin
      n_fail++; $display("FAIL single_grant: req_ready=%b expected %b", req_ready, er);
    end
    tick();
    req_valid = '0;
    n_checks++;
    if (red_C !== {64'd5, 64'd0} || inflight !== CW'(1) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_issue: red_C=%h inflight=%0d busy=%b expected %h/1/1", red_C, inflight, busy, {64'd5, 64'd0});
    end
    repeat (LAT + 4) tick();
    n_checks++;
    if (rsp_log.size() != 1) begin
      n_fail++; $display("FAIL single_rsp_count: got %0d expected 1", rsp_log.size());
    end else if (rsp_log[0].c != exp_q[0].c || rsp_log[0].id != 2 || rsp_log[0].t !== 64'd5) begin
      n_fail++;
      $display("FAIL single_rsp: cyc=%0d id=%0d T=%h expected cyc=%0d id=2 T=5",
               rsp_log[0].c, rsp_log[0].id, rsp_log[0].t, exp_q[0].c);
    end
    n_checks++;
    if (inflight !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: inflight=%0d busy=%b expected 0/0", inflight, busy);
    end
  endtask

  task automatic test_q_change();
    logic [NREQ-1:0] er;
    logic [63:0]     q2;
    logic            ok;
    rsp_log.delete(); exp_q.delete();
    q2 = rand_q();
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      req_C[K +: K] = rand_c(mq);
      #1;
      model_step(er);
      n_checks++;
      if (req_ready !== er) begin
        n_fail++; $display("FAIL qchg_grant cyc %0d: req_ready=%b expected %b", cyc, req_ready, er);
      end
      tick();
    end
    cfg_q_valid = 1'b1; cfg_q = q2; req_C[K +: K] = rand_c(mq);
    #1;
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL qchg_cfg_blocks_grant: req_ready=%b expected 0000", req_ready);
    end
    tick();
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      n_checks++;
      if (cfg_q_ready !== (model_inflight(cyc) == 0) || req_ready !== '0 || red_q !== mq) begin
        n_fail++;
        $display("FAIL qchg_drain cyc %0d: cfg_q_ready=%b req_ready=%b red_q=%h expected %b/0000/%h",
                 cyc, cfg_q_ready, req_ready, red_q, model_inflight(cyc) == 0, mq);
      end
      ok = cfg_q_ready;
      tick();
    end
    cfg_q_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL qchg_timeout: cfg_q_ready=0 expected 1 within 30 cycles");
    end
    mq = q2;
    n_checks++;
    if (red_q !== q2) begin
      n_fail++; $display("FAIL qchg_red_q: got %h expected %h", red_q, q2);
    end
    for (int i = 0; i < 4; i++) begin
      req_C[K +: K] = rand_c(mq);
      #1;
      model_step(er);
      n_checks++;
      if (req_ready !== er) begin
        n_fail++; $display("FAIL qchg_grant2 cyc %0d: req_ready=%b expected %b", cyc, req_ready, er);
      end
      tick();
    end
    req_valid = '0;
    repeat (LAT + 4) tick();
    n_checks++;
    if (rsp_log.size() != exp_q.size()) begin
      n_fail++; $display("FAIL qchg_rsp_count: got %0d expected %0d", rsp_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (rsp_log[i].c != exp_q[i].c || rsp_log[i].id != exp_q[i].id || rsp_log[i].t !== exp_q[i].t) begin
          n_fail++;
          $display("FAIL qchg_rsp[%0d]: cyc=%0d id=%0d T=%h expected cyc=%0d id=%0d T=%h", i,
                   rsp_log[i].c, rsp_log[i].id, rsp_log[i].t, exp_q[i].c, exp_q[i].id, exp_q[i].t);
        end
      end
    end
  endtask

  task automatic test_cfg_priority();
    logic [K-1:0] c_before;
    logic [63:0]  q3;
    q3 = rand_q();
    c_before = red_C;
    cfg_q_valid = 1'b1; cfg_q = q3; req_valid = 4'b0001; req_C[0 +: K] = rand_c(mq);
    #1;
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL prio_req_ready: got %b expected 0000", req_ready);
    end
    tick();
    n_checks++;
    if (inflight !== '0 || red_C !== c_before || req_ready !== '0 || cfg_q_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_drain: inflight=%0d red_C=%h req_ready=%b cfg_q_ready=%b expected 0/%h/0000/1",
               inflight, red_C, req_ready, cfg_q_ready, c_before);
    end
    tick();
    cfg_q_valid = 1'b0; req_valid = '0; mq = q3;
    n_checks++;
    if (red_q !== q3) begin
      n_fail++; $display("FAIL prio_red_q: got %h expected %h", red_q, q3);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] er;
    rsp_log.delete(); exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      req_valid = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++) req_C[r*K +: K] = rand_c(mq);
      #1;
      model_step(er);
      n_checks++;
      if (req_ready !== er) begin
        n_fail++; $display("FAIL rand_grant cyc %0d: req_ready=%b expected %b mask=%b", cyc, req_ready, er, req_valid);
      end
      tick();
    end
    req_valid = '0;
    repeat (LAT + 4) tick();
    n_checks++;
    if (rsp_log.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_rsp_count: got %0d expected %0d", rsp_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (rsp_log[i].c != exp_q[i].c || rsp_log[i].id != exp_q[i].id || rsp_log[i].t !== exp_q[i].t) begin
          n_fail++;
          $display("FAIL rand_rsp[%0d]: cyc=%0d id=%0d T=%h expected cyc=%0d id=%0d T=%h", i,
                   rsp_log[i].c, rsp_log[i].id, rsp_log[i].t, exp_q[i].c, exp_q[i].id, exp_q[i].t);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [NREQ-1:0] er;
    exp_q.delete();
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < NREQ; r++) req_C[r*K +: K] = rand_c(mq);
      #1;
      model_step(er);
      tick();
    end
    n_checks++;
    if (int'(inflight) != model_inflight(cyc)) begin
      n_fail++; $display("FAIL mid_inflight: got %0d expected %0d", inflight, model_inflight(cyc));
    end
    rsp_log.delete();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (inflight !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0 || red_q !== '0 || red_C !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_vals: inflight=%0d busy=%b rsp_valid=%b red_q=%h red_C=%h expected all 0",
               inflight, busy, rsp_valid, red_q, red_C);
    end
    tick();
    rst = 1'b1;
    mptr = NREQ - 1;
    exp_q.delete();
    for (int i = 0; i < LAT + 5; i++) begin
      #1;
      n_checks++;
      if (req_ready !== '0 || cfg_q_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_noq cyc %0d: req_ready=%b cfg_q_ready=%b expected 0000/1", cyc, req_ready, cfg_q_ready);
      end
      tick();
    end
    n_checks++;
    if (rsp_log.size() != 0) begin
      n_fail++; $display("FAIL mid_no_rsp: got %0d responses expected 0", rsp_log.size());
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] er;
    rsp_log.delete(); exp_q.delete();
    cfg_q_valid = 1'b1; cfg_q = rand_q();
    tick();
    mq = cfg_q; cfg_q_valid = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < NREQ; r++) req_C[r*K +: K] = rand_c(mq);
      #1;
      model_step(er);
      n_checks++;
      if (req_ready !== er || req_ready !== (NREQ'(1) << (i % NREQ))) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: req_ready=%b expected %b", i, req_ready, NREQ'(1) << (i % NREQ));
      end
      tick();
    end
    req_valid = '0;
    repeat (LAT + 4) tick();
    n_checks++;
    if (rsp_log.size() != 12) begin
      n_fail++; $display("FAIL rr_rsp_count: got %0d expected 12", rsp_log.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (rsp_log[i].c != exp_q[i].c || rsp_log[i].id != (i % NREQ) || rsp_log[i].t !== exp_q[i].t) begin
          n_fail++;
          $display("FAIL rr_rsp[%0d]: cyc=%0d id=%0d T=%h expected cyc=%0d id=%0d T=%h", i,
                   rsp_log[i].c, rsp_log[i].id, rsp_log[i].t, exp_q[i].c, i % NREQ, exp_q[i].t);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_noq();
    test_single();
    test_q_change();
    test_cfg_priority();
    test_random();
    test_reset_midflight();
    test_round_robin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
